// File: rtl/semaforo_ctrl_if.sv
// Request sensors and light outputs of the four-approach traffic-light controller.
// The sensor side (master) drives A..D; the controller (slave) drives the lights and phase.
interface semaforo_ctrl_if;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic       FA;
  logic       FB;
  logic       FC;
  logic       FD;
  logic       YA;
  logic       YB;
  logic       YC;
  logic       YD;
  logic [1:0] phase;

  modport master (
    output A, B, C, D,
    input  FA, FB, FC, FD, YA, YB, YC, YD, phase
  );

  modport slave (
    input  A, B, C, D,
    output FA, FB, FC, FD, YA, YB, YC, YD, phase
  );
endinterface

// File: rtl/semaforo_ctrl.sv
// Round-robin four-approach traffic-light controller with min/max green, yellow and all-red timing.
// Lights are registered from the next state, so there is no path from the sensors to the lamps.
module semaforo_ctrl #(
  parameter int CW          = 4,
  parameter int T_GREEN_MIN = 4,
  parameter int T_GREEN_MAX = 8,
  parameter int T_YELLOW    = 2,
  parameter int T_ALLRED    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  semaforo_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    ALLRED = 2'd3
  } state_t;

  localparam logic [CW-1:0] GMIN_LAST = CW'(T_GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_LAST = CW'(T_GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL_LAST  = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] AR_LAST   = CW'(T_ALLRED - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    pend, pend_nxt;
  logic [1:0]    grant, grant_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [3:0]    req;
  logic [3:0]    others;
  logic          green_done;
  logic [3:0]    green;
  logic [3:0]    yellow;
  logic [1:0]    phase_q;

  // First pending approach strictly after 'from'; offset 4 wraps back to 'from' itself.
  function automatic logic [1:0] pick(input logic [3:0] p, input logic [1:0] from);
    logic [1:0] r;
    logic [1:0] idx;
    logic       found;
    r     = from;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = from + 2'(i);
      if (!found && p[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign req        = {bus.D, bus.C, bus.B, bus.A};
  assign others     = pend & ~(4'b0001 << grant);
  assign green_done = (cnt >= GMIN_LAST) && (|others) && (!req[grant] || (cnt == GMAX_LAST));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    pend_nxt  = pend | req;
    if (state == GREEN) begin
      pend_nxt[grant] = 1'b0;
    end
    case (state)
      IDLE: begin
        if (|pend) begin
          state_nxt = GREEN;
          grant_nxt = pick(pend, ptr);
          ptr_nxt   = grant_nxt;
          cnt_nxt   = '0;
        end
      end
      GREEN: begin
        if (green_done) begin
          state_nxt = YELLOW;
          cnt_nxt   = '0;
        end else if (cnt != GMAX_LAST) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      YELLOW: begin
        if (cnt == YEL_LAST) begin
          state_nxt = ALLRED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ALLRED: begin
        if (cnt == AR_LAST) begin
          cnt_nxt = '0;
          if (|pend) begin
            state_nxt = GREEN;
            grant_nxt = pick(pend, ptr);
            ptr_nxt   = grant_nxt;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= 4'b0000;
      grant   <= 2'd0;
      ptr     <= 2'd3;
      green   <= 4'b0000;
      yellow  <= 4'b0000;
      phase_q <= 2'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend    <= pend_nxt;
      grant   <= grant_nxt;
      ptr     <= ptr_nxt;
      green   <= (state_nxt == GREEN)  ? (4'b0001 << grant_nxt) : 4'b0000;
      yellow  <= (state_nxt == YELLOW) ? (4'b0001 << grant_nxt) : 4'b0000;
      phase_q <= state_nxt;
    end
  end

  assign bus.FA    = green[0];
  assign bus.FB    = green[1];
  assign bus.FC    = green[2];
  assign bus.FD    = green[3];
  assign bus.YA    = yellow[0];
  assign bus.YB    = yellow[1];
  assign bus.YC    = yellow[2];
  assign bus.YD    = yellow[3];
  assign bus.phase = phase_q;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Bench for semaforo_ctrl: directed vector table, multi-cycle timing sequences and random
// traffic, all compared against a phase/elapsed-time model of the light schedule.
module tb_semaforo_ctrl;
  localparam int TGMIN = 4;
  localparam int TGMAX = 8;
  localparam int TY    = 2;
  localparam int TAR   = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  semaforo_ctrl_if bus();

  semaforo_ctrl #(
    .CW(4), .T_GREEN_MIN(TGMIN), .T_GREEN_MAX(TGMAX), .T_YELLOW(TY), .T_ALLRED(TAR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [9:0] cur;

  // Model: phase (0 idle,1 green,2 yellow,3 all-red), cycles already spent in it, who is lit.
  int     m_ph = 0;
  int     m_el = 0;
  int     m_g = 0;
  int     m_ptr = 3;
  bit [3:0] m_pend = 4'b0;

  typedef struct {
    bit         rst;
    bit [3:0]   req;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [9:0] mk(input logic [3:0] f, input logic [3:0] y, input logic [1:0] ph);
    return {f, y, ph};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {bus.FD, bus.FC, bus.FB, bus.FA, bus.YD, bus.YC, bus.YB, bus.YA, bus.phase};
  endfunction

  function automatic logic [9:0] model_vec();
    logic [3:0] lamp;
    lamp = 4'(1 << m_g);
    return mk((m_ph == 1) ? lamp : 4'b0, (m_ph == 2) ? lamp : 4'b0, 2'(m_ph));
  endfunction

  function automatic int pick(input bit [3:0] p, input int from);
    for (int off = 1; off <= 4; off++) begin
      int idx;
      idx = (from + off) % 4;
      if (p[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input bit r, input bit [3:0] req);
    bit [3:0] old;
    bit [3:0] oth;
    old = m_pend;
    if (!r) begin
      m_ph = 0; m_el = 0; m_pend = 4'b0; m_g = 0; m_ptr = 3;
      return;
    end
    m_pend = old | req;
    if (m_ph == 1) m_pend[m_g] = 1'b0;
    oth = old;
    oth[m_g] = 1'b0;
    case (m_ph)
      0: if (old != 0) begin
        m_g = pick(old, m_ptr); m_ptr = m_g; m_ph = 1; m_el = 0;
      end
      1: if (m_el + 1 >= TGMIN && oth != 0 && (!req[m_g] || m_el + 1 >= TGMAX)) begin
        m_ph = 2; m_el = 0;
      end else m_el++;
      2: if (m_el + 1 >= TY) begin m_ph = 3; m_el = 0; end else m_el++;
      default: if (m_el + 1 >= TAR) begin
        m_el = 0;
        if (old == 0) m_ph = 0;
        else begin m_g = pick(old, m_ptr); m_ptr = m_g; m_ph = 1; end
      end else m_el++;
    endcase
  endtask

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (F4 Y4 phase2) at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit [3:0] req);
    @(negedge clk);
    rst_n = r;
    bus.A = req[0]; bus.B = req[1]; bus.C = req[2]; bus.D = req[3];
    @(posedge clk);
    model_step(r, req);
    #1;
    cur = dut_vec();
    chk("model", cur, model_vec());
  endtask

  task automatic do_reset();
    cycle(1'b0, 4'hF);
    cycle(1'b0, 4'hF);
  endtask

  // Counts consecutive samples equal to the current one; bounded so a stuck DUT cannot hang.
  task automatic count_run(input bit [3:0] req, output int n);
    logic [9:0] v;
    v = cur;
    n = 0;
    while (cur === v && n < 64) begin
      n++;
      cycle(1'b1, req);
    end
  endtask

  task automatic add(input bit r, input bit [3:0] q, input logic [3:0] f, input logic [3:0] y,
                     input logic [1:0] ph);
    vec_t v;
    v.rst = r; v.req = q; v.exp = mk(f, y, ph);
    tbl.push_back(v);
  endtask

  initial begin
    int n;
    bit r;
    bit [3:0] q;
    rst_n = 1'b0;
    bus.A = 1'b0; bus.B = 1'b0; bus.C = 1'b0; bus.D = 1'b0;

    add(0, 4'hF, 4'h0, 4'h0, 2'd0);
    add(0, 4'hF, 4'h0, 4'h0, 2'd0);
    add(1, 4'h0, 4'h0, 4'h0, 2'd0);
    add(1, 4'h0, 4'h0, 4'h0, 2'd0);
    add(1, 4'h1, 4'h0, 4'h0, 2'd0);
    add(1, 4'h0, 4'h1, 4'h0, 2'd1);
    add(1, 4'h2, 4'h1, 4'h0, 2'd1);
    add(1, 4'h0, 4'h1, 4'h0, 2'd1);
    add(1, 4'h0, 4'h1, 4'h0, 2'd1);
    add(1, 4'h0, 4'h0, 4'h1, 2'd2);
    add(1, 4'h0, 4'h0, 4'h1, 2'd2);
    add(1, 4'h0, 4'h0, 4'h0, 2'd3);
    add(1, 4'h0, 4'h2, 4'h0, 2'd1);
    add(1, 4'h4, 4'h2, 4'h0, 2'd1);
    add(1, 4'h0, 4'h2, 4'h0, 2'd1);
    add(1, 4'h0, 4'h2, 4'h0, 2'd1);
    add(1, 4'h0, 4'h0, 4'h2, 2'd2);
    add(1, 4'h0, 4'h0, 4'h2, 2'd2);
    add(0, 4'h0, 4'h0, 4'h0, 2'd0);
    add(1, 4'h0, 4'h0, 4'h0, 2'd0);
    add(1, 4'h1, 4'h0, 4'h0, 2'd0);
    add(1, 4'h0, 4'h1, 4'h0, 2'd1);
    add(1, 4'h0, 4'h1, 4'h0, 2'd1);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].req);
      chk($sformatf("vec%0d", i), cur, tbl[i].exp);
    end

    // Lone A request rests on green indefinitely.
    do_reset();
    cycle(1'b1, 4'h1);
    cycle(1'b1, 4'h0);
    chk("rest_green", cur, mk(4'h1, 4'h0, 2'd1));
    count_run(4'h0, n);
    chk_int("rest_len", int'(n >= 20), 1);

    // A held with C waiting: green capped at the maximum.
    do_reset();
    cycle(1'b1, 4'h1);
    cycle(1'b1, 4'h1);
    chk("hold_green", cur, mk(4'h1, 4'h0, 2'd1));
    cycle(1'b1, 4'h5);
    count_run(4'h1, n);
    chk_int("hold_glen", n + 1, TGMAX);
    chk("hold_yel", cur, mk(4'h0, 4'h1, 2'd2));
    count_run(4'h1, n);
    chk_int("hold_ylen", n, TY);
    chk("hold_ar", cur, mk(4'h0, 4'h0, 2'd3));
    count_run(4'h1, n);
    chk_int("hold_arlen", n, TAR);
    chk("hold_nextc", cur, mk(4'h4, 4'h0, 2'd1));

    // All four at once from idle: A, B, C, D in turn, D rests.
    do_reset();
    cycle(1'b1, 4'hF);
    cycle(1'b1, 4'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_green%0d", i), cur, mk(4'(1 << i), 4'h0, 2'd1));
      count_run(4'h0, n);
      if (i < 3) begin
        chk_int("rr_glen", n, TGMIN);
        chk($sformatf("rr_yel%0d", i), cur, mk(4'h0, 4'(1 << i), 2'd2));
        count_run(4'h0, n);
        chk_int("rr_ylen", n, TY);
        chk("rr_ar", cur, mk(4'h0, 4'h0, 2'd3));
        count_run(4'h0, n);
        chk_int("rr_arlen", n, TAR);
      end else begin
        chk_int("rr_rest", int'(n >= 20), 1);
      end
    end

    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 99) != 0);
      for (int j = 0; j < 4; j++) q[j] = ($urandom_range(0, 7) == 0);
      cycle(r, q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
